tree_merge_arbiter: RTL and testbench
=====================================

Name: tree_merge_arbiter

Overview:
- Clocked, round-robin arbiter-merge for one router output port of the 16-leaf tree NoC.
- Shares one output link between NUM_IN packet sources (parent/child1/child2 scheme outputs).
- Holds the granted packet for a fixed forward latency, checks the packet parity field and keeps accept/error statistics.
- Replaces the random-winner merge, giving deterministic fairness for performance measurement.

Parameters:
- NUM_IN, 3: number of requesting inputs (>=2).
- PACKET_WIDTH, 16: packet width in bits.
- FL, 4: forward latency in cycles from accept to out_valid (>=1).
- DROP_BAD, 0: 1 = discard packets failing the parity check; 0 = forward them and count them.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  NUM_IN  per-input request; input i holds its data stable until accepted.
- in_ready  out  NUM_IN  one-hot accept strobe, combinational.
- in_data  in  NUM_IN*PACKET_WIDTH  packed packets; input i occupies bits [i*PW +: PW].
- out_valid  out  1  output packet valid.
- out_ready  in  1  downstream accept.
- out_data  out  PACKET_WIDTH  registered packet.
- out_src  out  $clog2(NUM_IN)  index of the input that supplied out_data.
- pkt_count  out  16  packets accepted, saturating.
- err_count  out  16  parity-failed packets accepted, saturating.

Behaviour:
- Reset values:
  - state=IDLE, ptr=NUM_IN-1, so input 0 has first priority.
  - out_valid=0, out_data=0, out_src=0.
  - pkt_count=0, err_count=0, cnt=0.
  - in_ready=0.
- Reset mid-operation drops any held packet without emitting it.
- Packet fields:
  - data [3:0], dest [7:4], src [11:8], bit12 reserved, parity bit13.
  - Packet is good iff pkt[13] == ^pkt[12:0].
- IDLE:
  - Search in_valid starting from (ptr+1) mod NUM_IN, wrapping. The first asserted input wins.
  - in_ready[winner]=1 in the same cycle (combinational). This is the accept cycle t.
  - On accept: latch out_data and out_src, set ptr=winner, increment pkt_count. If bad, increment err_count.
  - Counters saturate at 16'hFFFF.
  - No requests: stay in IDLE, in_ready=0.
- Bad packet with DROP_BAD=1: after the accept cycle, return to IDLE; out_valid is never raised.
- Otherwise, next state after accept:
  - FL==1: go to SEND.
  - FL>1: go to WAIT with cnt=FL-1.
- WAIT:
  - in_ready all 0.
  - Decrement cnt each cycle; when cnt==1, go to SEND.
  - Result: out_valid first high at cycle t+FL.
- SEND:
  - out_valid=1 with out_data/out_src stable until out_ready.
  - On out_valid&&out_ready, go to IDLE with out_valid=0 the next cycle.
  - Backpressure is unbounded; no timeout.
- Throughput: at most one packet per FL+1 cycles. No accept occurs in the same cycle as an output handshake.
- Fairness: a continuously requesting input waits at most NUM_IN-1 grants.
- in_ready is never asserted outside IDLE and is never asserted for an input whose in_valid is 0.

Decomposition:
- Package noc_pkg:
  - PACKET_WIDTH and the field bit-position constants.
  - State typedef enum {IDLE, WAIT, SEND}.
  - Function parity_ok(pkt).
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[NUM_IN], ptr.
  - Outputs: grant one-hot, grant_idx, any.
- The top holds the FSM, latency counter, data register and statistics counters.

Test Plan:
- Reset, then input 1 only, in_data[1]=16'h0905 (good), out_ready=1, FL=4.
  - in_ready[1] high at cycle t.
  - out_valid high at t+4 with out_data=16'h0905, out_src=1.
  - pkt_count=1, err_count=0.
- All three inputs held valid for 6 grants after reset.
  - Grant order 0,1,2,0,1,2.
  - in_ready never high for two inputs or in WAIT/SEND.
- Input 0 sends 16'h2905 (bad parity).
  - DROP_BAD=0: forwarded at t+4, err_count=1.
  - DROP_BAD=1: out_valid stays 0, FSM back in IDLE at t+1, err_count=1, pkt_count=1.
- out_ready=0 for 10 cycles in SEND.
  - out_valid and out_data held stable, no new in_ready.
  - Handshake on out_ready rise, IDLE next cycle.
- FL=1 build.
  - Accept at t, out_valid at t+1.
  - Back-to-back single-input traffic yields one packet every 2 cycles.
- rst asserted during WAIT.
  - Next cycle: out_valid=0, counters=0.
  - Subsequent grant goes to input 0 first.
  - Separately, force pkt_count to 16'hFFFF and accept a packet: the count stays 16'hFFFF.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the tree NoC router datapath: packet layout,
// arbiter FSM state encoding and the packet parity rule.
package noc_pkg;

    // Packet layout: data [3:0], dest [7:4], src [11:8], reserved [12], parity [13].
    localparam int PACKET_WIDTH = 16;
    localparam int RSVD_BIT     = 12;
    localparam int PAR_BIT      = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    // A packet is good when its parity bit equals the XOR of bits [12:0].
    function automatic logic parity_ok(input logic [PAR_BIT:0] pkt);
        return pkt[PAR_BIT] == (^pkt[RSVD_BIT:0]);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the search starts one position after ptr and
// wraps, so the most recently granted input has the lowest priority.
module rr_pick #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    // First asserted request found from (ptr+1) mod NUM_IN wins.
    always_comb begin
        logic [IDX_W-1:0] j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            j = IDX_W'((int'(ptr) + k) % NUM_IN);
            if (!any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = j;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tree_merge_arbiter.sv
// Round-robin merge of NUM_IN packet sources onto one router output link.
// A granted packet is held for FL cycles before being offered downstream;
// parity is checked on accept and accept/error statistics are kept.
module tree_merge_arbiter #(
    parameter int NUM_IN       = 3,
    parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
    parameter int FL           = 4,
    parameter int DROP_BAD     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              in_valid,
    output logic [NUM_IN-1:0]              in_ready,
    input  logic [NUM_IN*PACKET_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PACKET_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0]      out_src,
    output logic [15:0]                    pkt_count,
    output logic [15:0]                    err_count
);

    import noc_pkg::*;

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(FL + 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_src_q, out_src_d;
    logic [15:0]             pkt_count_q, pkt_count_d;
    logic [15:0]             err_count_q, err_count_d;

    logic [NUM_IN-1:0]       grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    any;
    logic [PACKET_WIDTH-1:0] in_pkt [NUM_IN];
    logic [PACKET_WIDTH-1:0] win_pkt;
    logic                    win_bad;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign in_pkt[i] = in_data[i*PACKET_WIDTH +: PACKET_WIDTH];
    end

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Winner's packet and its parity verdict, plus the accept strobe (IDLE only).
    always_comb begin
        win_pkt  = in_pkt[grant_idx];
        win_bad  = !parity_ok(win_pkt[PAR_BIT:0]);
        in_ready = (state_q == IDLE && !rst) ? grant : '0;
    end

    // Next-state logic: accept in IDLE, count down latency in WAIT, handshake in SEND.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    ptr_d       = grant_idx;
                    out_data_d  = win_pkt;
                    out_src_d   = grant_idx;
                    pkt_count_d = sat_inc(pkt_count_q);
                    if (win_bad) begin
                        err_count_d = sat_inc(err_count_q);
                    end
                    // A dropped packet frees the port immediately.
                    if (win_bad && DROP_BAD != 0) begin
                        state_d = IDLE;
                    end else if (FL == 1) begin
                        state_d = SEND;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(FL - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_IN - 1);
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_tree_merge_arbiter.sv
// Bench for tree_merge_arbiter: three builds (FL=4 forwarding, FL=4 dropping,
// FL=1 forwarding) share one stimulus bus; directed scenarios plus a
// randomized run against a cycle-age reference model.
module tb_tree_merge_arbiter;

    localparam int N  = 3;
    localparam int PW = 16;
    localparam int FL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*PW-1:0] in_data = '0;
    logic            out_ready = 1'b1;

    logic [N-1:0] a_ready, b_ready, c_ready;
    logic         a_ov, b_ov, c_ov;
    logic [PW-1:0] a_od, b_od, c_od;
    logic [1:0]   a_os, b_os, c_os;
    logic [15:0]  a_pc, b_pc, c_pc, a_ec, b_ec, c_ec;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    tree_merge_arbiter #(.NUM_IN(N), .PACKET_WIDTH(PW), .FL(FL), .DROP_BAD(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .in_data(in_data),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_src(a_os),
        .pkt_count(a_pc), .err_count(a_ec));

    tree_merge_arbiter #(.NUM_IN(N), .PACKET_WIDTH(PW), .FL(FL), .DROP_BAD(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_src(b_os),
        .pkt_count(b_pc), .err_count(b_ec));

    tree_merge_arbiter #(.NUM_IN(N), .PACKET_WIDTH(PW), .FL(1), .DROP_BAD(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready), .in_data(in_data),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .out_src(c_os),
        .pkt_count(c_pc), .err_count(c_ec));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '1;
        in_data = {3{16'h0905}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total_cnt++; if (a_ready !== 3'b000) $display("FAIL reset_ready_in_rst got=%b exp=000", a_ready); else pass_cnt++;
        rst = 1'b0;
        in_valid = '0;
        #1;
        total_cnt++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_ov); else pass_cnt++;
        total_cnt++; if (a_od !== 16'h0000) $display("FAIL reset_out_data got=%h exp=0000", a_od); else pass_cnt++;
        total_cnt++; if (a_os !== 2'd0) $display("FAIL reset_out_src got=%0d exp=0", a_os); else pass_cnt++;
        total_cnt++; if (a_pc !== 16'd0) $display("FAIL reset_pkt_count got=%0d exp=0", a_pc); else pass_cnt++;
        total_cnt++; if (a_ec !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", a_ec); else pass_cnt++;
        total_cnt++; if (b_ov !== 1'b0 || c_ov !== 1'b0) $display("FAIL reset_out_valid_bc got=%b%b exp=00", b_ov, c_ov); else pass_cnt++;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        in_data[1*PW +: PW] = 16'h0905;
        in_valid = 3'b010;
        #1;
        total_cnt++; if (a_ready !== 3'b010) $display("FAIL single_accept got=%b exp=010", a_ready); else pass_cnt++;
        tick();
        in_valid = 3'b001;
        for (int k = 1; k < FL; k++) begin
            #1;
            total_cnt++; if (a_ready !== 3'b000) $display("FAIL single_wait_ready t+%0d got=%b exp=000", k, a_ready); else pass_cnt++;
            total_cnt++; if (a_ov !== 1'b0) $display("FAIL single_wait_valid t+%0d got=%b exp=0", k, a_ov); else pass_cnt++;
            tick();
        end
        in_valid = 3'b000;
        #1;
        total_cnt++; if (a_ov !== 1'b1) $display("FAIL single_out_valid got=%b exp=1", a_ov); else pass_cnt++;
        total_cnt++; if (a_od !== 16'h0905) $display("FAIL single_out_data got=%h exp=0905", a_od); else pass_cnt++;
        total_cnt++; if (a_os !== 2'd1) $display("FAIL single_out_src got=%0d exp=1", a_os); else pass_cnt++;
        total_cnt++; if (a_pc !== 16'd1) $display("FAIL single_pkt_count got=%0d exp=1", a_pc); else pass_cnt++;
        total_cnt++; if (a_ec !== 16'd0) $display("FAIL single_err_count got=%0d exp=0", a_ec); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (a_ov !== 1'b0) $display("FAIL single_after_handshake got=%b exp=0", a_ov); else pass_cnt++;
        tick();
    endtask

    // All inputs request continuously: grants every FL+1 cycles in order 0,1,2,...
    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        in_data = {3{16'h0905}};
        in_valid = 3'b111;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6 * (FL + 1); cyc++) begin
            exp = (cyc % (FL + 1) == 0) ? N'(1 << ((cyc / (FL + 1)) % N)) : '0;
            #1;
            total_cnt++; if (a_ready !== exp) $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, a_ready, exp); else pass_cnt++;
            tick();
        end
        in_valid = '0;
    endtask

    task automatic test_bad_parity();
        do_reset();
        in_data[0*PW +: PW] = 16'h2905;
        in_data[1*PW +: PW] = 16'h0905;
        in_valid = 3'b001;
        #1;
        total_cnt++; if (a_ready !== 3'b001 || b_ready !== 3'b001) $display("FAIL bad_accept got=%b/%b exp=001/001", a_ready, b_ready); else pass_cnt++;
        tick();
        in_valid = 3'b010;
        #1;
        total_cnt++; if (b_ready !== 3'b010) $display("FAIL drop_idle_next got=%b exp=010", b_ready); else pass_cnt++;
        total_cnt++; if (b_pc !== 16'd1 || b_ec !== 16'd1) $display("FAIL drop_counts got=%0d/%0d exp=1/1", b_pc, b_ec); else pass_cnt++;
        total_cnt++; if (a_ready !== 3'b000) $display("FAIL fwd_wait_ready got=%b exp=000", a_ready); else pass_cnt++;
        tick();
        in_valid = 3'b000;
        for (int k = 2; k < FL; k++) begin
            #1;
            total_cnt++; if (a_ov !== 1'b0 || b_ov !== 1'b0) $display("FAIL bad_early_valid t+%0d got=%b%b exp=00", k, a_ov, b_ov); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (a_ov !== 1'b1 || a_od !== 16'h2905 || a_os !== 2'd0) $display("FAIL fwd_bad_out got=%b/%h/%0d exp=1/2905/0", a_ov, a_od, a_os); else pass_cnt++;
        total_cnt++; if (a_ec !== 16'd1 || a_pc !== 16'd1) $display("FAIL fwd_bad_counts got=%0d/%0d exp=1/1", a_ec, a_pc); else pass_cnt++;
        total_cnt++; if (b_ov !== 1'b0) $display("FAIL drop_never_valid got=%b exp=0", b_ov); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (b_ov !== 1'b1 || b_od !== 16'h0905 || b_os !== 2'd1) $display("FAIL drop_next_good got=%b/%h/%0d exp=1/0905/1", b_ov, b_od, b_os); else pass_cnt++;
        total_cnt++; if (b_pc !== 16'd2 || b_ec !== 16'd1) $display("FAIL drop_next_counts got=%0d/%0d exp=2/1", b_pc, b_ec); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data = {16'h0A5F, 16'h0905, 16'h0905};
        in_valid = 3'b100;
        out_ready = 1'b0;
        #1;
        total_cnt++; if (a_ready !== 3'b100) $display("FAIL bp_accept got=%b exp=100", a_ready); else pass_cnt++;
        tick();
        in_valid = 3'b111;
        repeat (FL - 1) tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            total_cnt++; if (a_ov !== 1'b1 || a_od !== 16'h0A5F || a_os !== 2'd2) $display("FAIL bp_hold k=%0d got=%b/%h/%0d exp=1/0a5f/2", k, a_ov, a_od, a_os); else pass_cnt++;
            total_cnt++; if (a_ready !== 3'b000) $display("FAIL bp_no_ready k=%0d got=%b exp=000", k, a_ready); else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (a_ov !== 1'b1 || a_ready !== 3'b000) $display("FAIL bp_handshake got=%b/%b exp=1/000", a_ov, a_ready); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (a_ov !== 1'b0 || a_ready !== 3'b001) $display("FAIL bp_idle_after got=%b/%b exp=0/001", a_ov, a_ready); else pass_cnt++;
        tick();
        in_valid = '0;
    endtask

    task automatic test_fl1();
        do_reset();
        in_data[0*PW +: PW] = 16'h0905;
        in_valid = 3'b001;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            total_cnt++; if (c_ready !== ((k % 2 == 0) ? 3'b001 : 3'b000)) $display("FAIL fl1_ready k=%0d got=%b", k, c_ready); else pass_cnt++;
            total_cnt++; if (c_ov !== (k % 2 == 1)) $display("FAIL fl1_valid k=%0d got=%b exp=%0d", k, c_ov, k % 2); else pass_cnt++;
            if (k % 2 == 1) begin
                total_cnt++; if (c_od !== 16'h0905) $display("FAIL fl1_data k=%0d got=%h exp=0905", k, c_od); else pass_cnt++;
            end
            tick();
        end
        in_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_data[2*PW +: PW] = 16'h0905;
        in_valid = 3'b100;
        #1;
        total_cnt++; if (a_ready !== 3'b100) $display("FAIL mid_accept got=%b exp=100", a_ready); else pass_cnt++;
        tick();
        in_valid = '0;
        #1;
        total_cnt++; if (a_pc !== 16'd1) $display("FAIL mid_pre_count got=%0d exp=1", a_pc); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++; if (a_ov !== 1'b0 || a_pc !== 16'd0 || a_ec !== 16'd0) $display("FAIL mid_after_rst got=%b/%0d/%0d exp=0/0/0", a_ov, a_pc, a_ec); else pass_cnt++;
        for (int k = 0; k < FL + 2; k++) begin
            #1;
            total_cnt++; if (a_ov !== 1'b0) $display("FAIL mid_dropped_emitted k=%0d got=%b exp=0", k, a_ov); else pass_cnt++;
            tick();
        end
        in_data = {3{16'h0905}};
        in_valid = 3'b111;
        #1;
        total_cnt++; if (a_ready !== 3'b001) $display("FAIL mid_first_grant got=%b exp=001", a_ready); else pass_cnt++;
        tick();
        in_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        force dut_a.pkt_count_q = 16'hFFFF;
        tick();
        release dut_a.pkt_count_q;
        in_data[0*PW +: PW] = 16'h0905;
        in_valid = 3'b001;
        #1;
        total_cnt++; if (a_pc !== 16'hFFFF || a_ready !== 3'b001) $display("FAIL sat_pre got=%h/%b exp=ffff/001", a_pc, a_ready); else pass_cnt++;
        tick();
        in_valid = '0;
        #1;
        total_cnt++; if (a_pc !== 16'hFFFF) $display("FAIL sat_pkt_count got=%h exp=ffff", a_pc); else pass_cnt++;
        total_cnt++; if (a_ec !== 16'd0) $display("FAIL sat_err_count got=%h exp=0000", a_ec); else pass_cnt++;
        tick();
    endtask

    // Reference model: a held packet becomes visible FL cycles after its accept
    // and leaves on handshake; while nothing is held, the next requester after
    // the last winner (cyclically) is accepted.
    task automatic test_random();
        int           m_last, m_age, win, drop_idx;
        bit           m_hold, exp_ov, bad;
        logic [PW-1:0] m_data, p;
        logic [1:0]   m_src;
        logic [15:0]  m_pc, m_ec;
        logic [N-1:0] exp_ready;
        do_reset();
        m_last = N - 1; m_hold = 0; m_age = 0; m_pc = 0; m_ec = 0;
        m_data = '0; m_src = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && ($urandom % 3 == 0)) begin
                    in_valid[i] = 1'b1;
                    in_data[i*PW +: PW] = PW'($urandom);
                end
            end
            out_ready = ($urandom % 4) != 0;
            win = -1;
            if (!m_hold) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (win < 0 && in_valid[j]) win = j;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            exp_ov = m_hold && (m_age >= FL);
            #1;
            total_cnt++; if (a_ready !== exp_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, a_ready, exp_ready); else pass_cnt++;
            total_cnt++; if (a_ov !== exp_ov) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, a_ov, exp_ov); else pass_cnt++;
            if (exp_ov) begin
                total_cnt++; if (a_od !== m_data || a_os !== m_src) $display("FAIL rnd_out cyc=%0d got=%h/%0d exp=%h/%0d", cyc, a_od, a_os, m_data, m_src); else pass_cnt++;
            end
            total_cnt++; if (a_pc !== m_pc || a_ec !== m_ec) $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, a_pc, a_ec, m_pc, m_ec); else pass_cnt++;
            drop_idx = -1;
            if (win >= 0) begin
                p = in_data[win*PW +: PW];
                bad = (p[13] != ^p[12:0]);
                m_last = win;
                m_pc = m_pc + 16'd1;
                if (bad) m_ec = m_ec + 16'd1;
                m_hold = 1; m_age = 1; m_data = p; m_src = 2'(win);
                drop_idx = win;
            end else if (m_hold) begin
                if (exp_ov && out_ready) m_hold = 0;
                else m_age++;
            end
            tick();
            if (drop_idx >= 0) in_valid[drop_idx] = 1'b0;
        end
        in_valid = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_bad_parity();
        test_backpressure();
        test_fl1();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
